// File: rtl/cpu_pkg.sv
// Shared CPU types: byte-wide word, opcode enum and the
// immediate-form predicate used by fetch and decode.
package cpu_pkg;

    typedef logic [7:0] word;

    typedef enum logic [7:0] {
        NOP  = 8'h00,
        ADDI = 8'h01,
        WO   = 8'h02,
        ADD  = 8'h03,
        LDI  = 8'h04,
        JMP  = 8'h05
    } e_instr;

    function automatic logic has_imm(e_instr op);
        return (op == ADDI) || (op == LDI);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control inputs, ROM port and decode stage.
// master = fetch unit, slave = surrounding core / memory.
interface instr_fetch_if #(
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic             stall;
    logic             branch_en;
    word              branch_addr;
    word              mem_addr;
    e_instr           mem_instr;
    word              mem_imm;
    e_instr           dec_instr;
    word              dec_imm;
    word              dec_pc;
    logic             dec_valid;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        input  stall, branch_en, branch_addr,
        input  mem_instr, mem_imm,
        output mem_addr,
        output dec_instr, dec_imm, dec_pc,
        output dec_valid, fetch_cnt
    );

    modport slave (
        output stall, branch_en, branch_addr,
        output mem_instr, mem_imm,
        input  mem_addr,
        input  dec_instr, dec_imm, dec_pc,
        input  dec_valid, fetch_cnt
    );

endinterface

// File: rtl/instr_fetch.sv
// PC / fetch sequencer feeding a 1-cycle ROM and a registered
// decode stage; handles branch redirect, stall replay, counter.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter word RESET_PC = 8'h00,
    parameter int  CNT_W    = 16
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

    typedef enum logic {
        S_FILL,
        S_RUN
    } e_fetch_state;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    e_fetch_state state, state_nxt;
    word          req_pc;
    word          next_pc;
    logic         capture;

    // Next address and action for the data now on mem_*
    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        next_pc      = req_pc + (has_imm(bus.mem_instr) ? 8'd2 : 8'd1);
        bus.mem_addr = req_pc;
        if (rst) begin
            state_nxt    = S_FILL;
            bus.mem_addr = RESET_PC;
        end else begin
            unique case (state)
                S_FILL: begin
                    state_nxt    = S_RUN;
                    bus.mem_addr = RESET_PC;
                end
                S_RUN: begin
                    if (bus.branch_en) begin
                        bus.mem_addr = bus.branch_addr;
                    end else if (bus.stall) begin
                        bus.mem_addr = req_pc;
                    end else begin
                        capture      = 1'b1;
                        bus.mem_addr = next_pc;
                    end
                end
                default: bus.mem_addr = RESET_PC;
            endcase
        end
    end

    // State, PC tracking and decode-stage capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FILL;
            req_pc        <= RESET_PC;
            bus.dec_valid <= 1'b0;
            bus.dec_instr <= NOP;
            bus.dec_imm   <= 8'h00;
            bus.dec_pc    <= 8'h00;
            bus.fetch_cnt <= '0;
        end else begin
            state  <= state_nxt;
            req_pc <= bus.mem_addr;
            if (state == S_RUN) begin
                if (bus.branch_en) begin
                    bus.dec_valid <= 1'b0;
                end else if (capture) begin
                    bus.dec_instr <= bus.mem_instr;
                    bus.dec_imm   <= has_imm(bus.mem_instr)
                                     ? bus.mem_imm : 8'h00;
                    bus.dec_pc    <= req_pc;
                    bus.dec_valid <= 1'b1;
                    if (bus.fetch_cnt != CNT_MAX)
                        bus.fetch_cnt <= bus.fetch_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and fetch sequencer that sits directly upstream of `instr_mem` and feeds the decoder. It drives the synchronous ROM address and captures the returned opcode/immediate pair into a registered decode stage. It advances the PC by one or two bytes depending on whether the opcode carries an immediate. It also handles branch redirects, decoder back-pressure and a fetched-instruction counter.

## Interface
- `RESET_PC`, `8'h00`: first fetch address after reset
- `CNT_W`, `16`: width of the fetched-instruction counter
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  decoder cannot accept; hold the decode stage
- `branch_en`  in  1  redirect fetch this cycle
- `branch_addr`  in  word  redirect target
- `mem_addr`  out  word  combinational address to `instr_mem` (1-cycle read latency)
- `mem_instr`  in  e_instr  opcode byte returned for the address issued last cycle
- `mem_imm`  in  word  byte following it (`addr+1`, mod 256)
- `dec_instr`  out  e_instr  registered opcode to decoder
- `dec_imm`  out  word  registered immediate; 0 when opcode has none
- `dec_pc`  out  word  address of `dec_instr`
- `dec_valid`  out  1  decode stage holds a real instruction
- `fetch_cnt`  out  CNT_W  count of instructions delivered; saturates at all-ones

## Operation
- `req_pc`: the address whose data is present on `mem_*` this cycle. Length `len = has_imm(mem_instr) ? 2 : 1`. `next_pc = req_pc + len`, mod 256.
- FSM states:
  - `S_FILL`: entered on `rst`. No capture; `mem_addr = RESET_PC`. Always goes to `S_RUN` next cycle.
  - `S_RUN`: steady state.
- Priority in `S_RUN`, evaluated per cycle:
  - `branch_en` (highest, overrides `stall`):
    - `mem_addr = branch_addr`; `req_pc <= branch_addr`
    - `dec_valid <= 0`; `dec_*` data hold
    - the instruction currently on `mem_*` is discarded
  - `stall`:
    - `mem_addr = req_pc` (replay, so the same data returns next cycle); `req_pc` holds
    - all `dec_*` hold, including `dec_valid`; counter holds
  - otherwise:
    - `dec_instr <= mem_instr`; `dec_imm <= has_imm ? mem_imm : 0`; `dec_pc <= req_pc`; `dec_valid <= 1`
    - `mem_addr = next_pc`; `req_pc <= next_pc`
    - `fetch_cnt` increments unless saturated
- While `rst = 1`: `mem_addr = RESET_PC` combinationally.
- Wrap-around: no fault at either boundary.
  - Immediate opcode at `8'hFF` takes its immediate from `8'h00`, and `next_pc = 8'h01`.
  - Single-byte opcode at `8'hFF` gives `next_pc = 8'h00`.
- `branch_en` in `S_FILL` is ignored; the reset fetch completes first.

## Timing
- Reset values:
  - `dec_valid 0`, `dec_instr NOP`, `dec_imm 0`, `dec_pc 0`, `fetch_cnt 0`
  - `req_pc RESET_PC`, state `S_FILL`
- `rst` mid-operation takes effect at the next edge, overriding `stall` and `branch_en`. `dec_valid` drops to 0 on that edge.
- Latency:
  - `mem_addr` issued in cycle n → data on `mem_*` in n+1 → on `dec_*` in n+2.
  - First valid decode output: 2 cycles after `rst` deasserts. Cycle 1 is `S_FILL`; capture happens on the edge ending cycle 2.
- Throughput: one instruction per cycle with no stall or branch.
- Branch: taken in cycle n; the target appears on `dec_*` with `dec_valid = 1` after the edge ending n+1. Exactly one bubble.
- Combinational path `mem_instr → has_imm → next_pc → mem_addr` is intentional.

## Structure
- `cpu_pkg` holds `word`, `e_instr` and a new function `has_imm(e_instr)`. It returns 1 for immediate-form opcodes (`ADDI`, others as added) and is shared with the decoder.
- State enum `e_fetch_state {S_FILL, S_RUN}` is local to the module.
- No sub-module; the saturating counter stays inline.

## Test plan
- Reset and fill:
  - Stimulus: ROM = `{NOP, ADDI, FF, WO}`; hold `rst` 3 cycles, then release.
  - Required: `mem_addr = 00` during reset. Then `dec_valid = 1` with `NOP`/`pc 00`, then `ADDI`/`imm FF`/`pc 01`, then `WO`/`pc 03`. Address `02` is never delivered as an opcode; `fetch_cnt = 3`.
- Stall:
  - Stimulus: assert `stall` 3 cycles while `dec_pc = 01`.
  - Required: `dec_*` frozen at `ADDI`/`FF`/`01`; `mem_addr = 03` replayed each cycle. After release, `WO`/`pc 03` appears on the next edge; counter +0 during stall.
- Branch:
  - Stimulus: `branch_en` with `branch_addr = 00` while `WO` is being fetched.
  - Required: one cycle with `dec_valid = 0`, then `NOP`/`pc 00`; `WO` is not counted.
- Branch and stall together:
  - Stimulus: assert both in the same cycle.
  - Required: behaves exactly as branch; `dec_valid = 0`.
- Wrap-around:
  - Stimulus: `ADDI` at `FF`, immediate at `00`.
  - Required: `dec_imm = rom[00]`, `dec_pc = FF`, next `mem_addr = 01`.
- Reset mid-operation:
  - Stimulus: `rst` asserted with `stall = 1` and `dec_valid = 1`.
  - Required: on the next edge `dec_valid = 0` and `fetch_cnt = 0`. Refetch starts at `RESET_PC`.
